// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - 3x3 sliding-window generator over a padded raster-order image
// Two line buffers feed a 3x3 shift register; windows are flagged only when fully inside the frame.
module window_gen_3x3 #(
    parameter int IMG_W = 258,
    parameter int IMG_H = 258,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [DW-1:0]   pix_in,
    input  logic            pix_valid,
    output logic [9*DW-1:0] win_out,
    output logic            win_valid,
    output logic [7:0]      out_row,
    output logic [7:0]      out_col,
    output logic            done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_in_col;
    logic [RW-1:0] r_in_row;

    logic [DW-1:0] r_lb1 [IMG_W];
    logic [DW-1:0] r_lb2 [IMG_W];

    logic [9*DW-1:0] r_win;
    logic            r_win_valid;
    logic            r_done;
    logic [7:0]      r_out_row;
    logic [7:0]      r_out_col;

    logic          w_accept;
    logic          w_start;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_frame_last;
    logic          w_win_inside;
    logic [DW-1:0] w_lb1_rd;
    logic [DW-1:0] w_lb2_rd;
    logic [DW-1:0] w_new_col [3];

    assign w_accept     = (r_state == S_RUN) && pix_valid;
    assign w_start      = (r_state == S_IDLE) && en;
    assign w_col_last   = (r_in_col == CW'(IMG_W - 1));
    assign w_row_last   = (r_in_row == RW'(IMG_H - 1));
    assign w_frame_last = w_accept && w_col_last && w_row_last;
    assign w_win_inside = (r_in_row >= RW'(2)) && (r_in_col >= CW'(2));

    assign w_lb1_rd     = r_lb1[r_in_col];
    assign w_lb2_rd     = r_lb2[r_in_col];
    assign w_new_col[0] = w_lb2_rd;
    assign w_new_col[1] = w_lb1_rd;
    assign w_new_col[2] = pix_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_nxt = S_RUN;
            S_RUN:   if (w_frame_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_start) begin
            r_in_col <= '0;
            r_in_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_in_col <= '0;
                r_in_row <= w_row_last ? '0 : r_in_row + RW'(1);
            end else begin
                r_in_col <= r_in_col + CW'(1);
            end
        end
    end

    // Line buffers carry no reset: rows 0 and 1 overwrite every column before any valid window reads them.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            r_lb1[r_in_col] <= pix_in;
            r_lb2[r_in_col] <= w_lb1_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win       <= '0;
            r_win_valid <= 1'b0;
            r_done      <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
        end else begin
            r_win_valid <= 1'b0;
            r_done      <= w_frame_last;
            if (w_accept) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[3*DW*i +: 3*DW] <= {w_new_col[i],
                                              r_win[3*DW*i + 2*DW +: DW],
                                              r_win[3*DW*i + DW +: DW]};
                end
                if (w_win_inside) begin
                    r_win_valid <= 1'b1;
                    r_out_row   <= 8'(r_in_row - RW'(2));
                    r_out_col   <= 8'(r_in_col - CW'(2));
                end
            end
        end
    end

    assign win_out   = r_win;
    assign win_valid = r_win_valid;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;
    assign done      = r_done;

endmodule
